return_coin_controller: RTL and testbench

Sequential front end of the vending-machine change path. It tracks customer inactivity with a wait-time countdown. On timeout or on an explicit return request, it dispenses the outstanding balance as a greedy sequence of one-hot coins on `o_return_coin`, one coin per cycle. `o_return_coin` and `o_wait_time` feed the combinational next-state calculator, which subtracts `return_total` from the balance register in the same cycle each coin is asserted.

---
 rtl/return_coin_controller.sv | 102 ++++++++++
 tb/tb_return_coin_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/return_coin_controller.sv
// Change-return front end: inactivity countdown plus greedy one-coin-per-cycle
// dispensing of the outstanding balance on timeout or customer request.
module return_coin_controller #(
  parameter int unsigned kTotalBits = 31,
  parameter int unsigned kNumCoins  = 3,
  parameter int unsigned kNumItems  = 4,
  parameter int unsigned kCoin0     = 100,
  parameter int unsigned kCoin1     = 500,
  parameter int unsigned kCoin2     = 1000,
  parameter int unsigned kWaitTime  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [kNumCoins-1:0]  i_input_coin,
  input  logic [kNumItems-1:0]  i_output_item,
  input  logic                  i_trigger_return,
  input  logic [kTotalBits-1:0] current_total,
  output logic [kNumCoins-1:0]  o_return_coin,
  output logic [31:0]           o_wait_time,
  output logic                  o_returning
);

  localparam logic [kTotalBits-1:0] Coin0    = kTotalBits'(kCoin0);
  localparam logic [kTotalBits-1:0] Coin1    = kTotalBits'(kCoin1);
  localparam logic [kTotalBits-1:0] Coin2    = kTotalBits'(kCoin2);
  localparam logic [31:0]           WaitInit = 32'(kWaitTime);

  typedef enum logic [1:0] {StIdle, StCount, StReturn} state_e;

  state_e                  state_q, state_d;
  logic [kTotalBits-1:0]   rem_q, rem_d;
  logic [kNumCoins-1:0]    coin_d;
  logic [31:0]             wait_d;
  logic                    activity;

  assign activity    = (|i_input_coin) || (|i_output_item);
  assign o_returning = (state_q == StReturn);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    wait_d  = o_wait_time;
    coin_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (activity) begin
          state_d = StCount;
          wait_d  = WaitInit;
        end else if (i_trigger_return && (current_total >= Coin0)) begin
          state_d = StReturn;
          rem_d   = current_total;
        end
      end
      StCount: begin
        if (activity) begin
          wait_d = WaitInit;
        end else if (i_trigger_return || (o_wait_time == 32'd1)) begin
          wait_d = '0;
          if (current_total >= Coin0) begin
            state_d = StReturn;
            rem_d   = current_total;
          end else begin
            state_d = StIdle;
          end
        end else begin
          wait_d = o_wait_time - 32'd1;
        end
      end
      StReturn: begin
        // Greedy: largest coin that still fits; rem can never go negative.
        if (rem_q >= Coin2) begin
          coin_d[2] = 1'b1;
          rem_d     = rem_q - Coin2;
        end else if (rem_q >= Coin1) begin
          coin_d[1] = 1'b1;
          rem_d     = rem_q - Coin1;
        end else if (rem_q >= Coin0) begin
          coin_d[0] = 1'b1;
          rem_d     = rem_q - Coin0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      rem_q         <= '0;
      o_return_coin <= '0;
      o_wait_time   <= '0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      o_return_coin <= coin_d;
      o_wait_time   <= wait_d;
    end
  end

endmodule

// File: tb/tb_return_coin_controller.sv
// Vector-table bench for return_coin_controller with an expected-output queue,
// plus a hand-written reset-during-return sequence.
module tb_return_coin_controller;

  logic        clk;
  logic        reset;
  logic [2:0]  i_input_coin;
  logic [3:0]  i_output_item;
  logic        i_trigger_return;
  logic [30:0] current_total;
  logic [2:0]  o_return_coin;
  logic [31:0] o_wait_time;
  logic        o_returning;

  int n_cmp = 0;
  int n_bad = 0;

  return_coin_controller dut (
    .clk              (clk),
    .reset            (reset),
    .i_input_coin     (i_input_coin),
    .i_output_item    (i_output_item),
    .i_trigger_return (i_trigger_return),
    .current_total    (current_total),
    .o_return_coin    (o_return_coin),
    .o_wait_time      (o_wait_time),
    .o_returning      (o_returning)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  coin;
    logic [3:0]  item;
    logic        trig;
    logic [30:0] total;
    logic [2:0]  e_coin;
    logic [31:0] e_wait;
    logic        e_ret;
  } vec_t;

  typedef struct {
    int          idx;
    logic [2:0]  e_coin;
    logic [31:0] e_wait;
    logic        e_ret;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic void add(input logic [2:0] coin, input logic [3:0] item, input logic trig,
                              input int total, input logic [2:0] ec, input int ew,
                              input logic er);
    vec_t v;
    v.coin   = coin;
    v.item   = item;
    v.trig   = trig;
    v.total  = 31'(total);
    v.e_coin = ec;
    v.e_wait = 32'(ew);
    v.e_ret  = er;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] ec, input logic [31:0] ew,
                               input logic er);
    check({tag, " coin"}, 32'(o_return_coin), 32'(ec));
    check({tag, " wait"}, o_wait_time, ew);
    check({tag, " returning"}, 32'(o_returning), 32'(er));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;

    // Idle, then a coin starts the countdown.
    add(3'b000, 4'h0, 1'b0,    0, 3'b000,  0, 1'b0);
    add(3'b010, 4'h0, 1'b0,    0, 3'b000, 10, 1'b0);
    // Trigger in COUNT with 1600: 1000, 500, 100, then done.
    add(3'b000, 4'h0, 1'b1, 1600, 3'b000,  0, 1'b1);
    add(3'b000, 4'h0, 1'b0, 1600, 3'b100,  0, 1'b1);
    add(3'b000, 4'h0, 1'b0,  600, 3'b010,  0, 1'b1);
    add(3'b000, 4'h0, 1'b0,  100, 3'b001,  0, 1'b1);
    add(3'b000, 4'h0, 1'b0,    0, 3'b000,  0, 1'b0);
    add(3'b000, 4'h0, 1'b0,    0, 3'b000,  0, 1'b0);
    // Timeout after a 500 coin: 10..1, then RETURN and one 500 coin.
    add(3'b010, 4'h0, 1'b0,  500, 3'b000, 10, 1'b0);
    for (int w = 9; w >= 1; w--) add(3'b000, 4'h0, 1'b0, 500, 3'b000, w, 1'b0);
    add(3'b000, 4'h0, 1'b0,  500, 3'b000,  0, 1'b1);
    add(3'b000, 4'h0, 1'b0,  500, 3'b010,  0, 1'b1);
    add(3'b000, 4'h0, 1'b0,    0, 3'b000,  0, 1'b0);
    add(3'b000, 4'h0, 1'b0,    0, 3'b000,  0, 1'b0);
    // Reload at wait==1, and trigger dropped when it meets an item dispense.
    add(3'b001, 4'h0, 1'b0,  100, 3'b000, 10, 1'b0);
    for (int w = 9; w >= 1; w--) add(3'b000, 4'h0, 1'b0, 100, 3'b000, w, 1'b0);
    add(3'b001, 4'h0, 1'b0,  200, 3'b000, 10, 1'b0);
    add(3'b000, 4'h1, 1'b1,  200, 3'b000, 10, 1'b0);
    add(3'b000, 4'h0, 1'b0,  200, 3'b000,  9, 1'b0);
    // Empty balance: trigger in COUNT and in IDLE both leave no coins.
    add(3'b000, 4'h0, 1'b1,    0, 3'b000,  0, 1'b0);
    add(3'b000, 4'h0, 1'b0,    0, 3'b000,  0, 1'b0);
    add(3'b000, 4'h0, 1'b1,    0, 3'b000,  0, 1'b0);
    add(3'b000, 4'h0, 1'b0,    0, 3'b000,  0, 1'b0);
    // Residual 50 after timeout goes straight back to IDLE.
    add(3'b001, 4'h0, 1'b0,   50, 3'b000, 10, 1'b0);
    for (int w = 9; w >= 1; w--) add(3'b000, 4'h0, 1'b0, 50, 3'b000, w, 1'b0);
    add(3'b000, 4'h0, 1'b0,   50, 3'b000,  0, 1'b0);
    add(3'b000, 4'h0, 1'b0,   50, 3'b000,  0, 1'b0);
    // 2100 from IDLE with coin input and held trigger ignored during RETURN.
    add(3'b000, 4'h0, 1'b1, 2100, 3'b000,  0, 1'b1);
    add(3'b001, 4'h0, 1'b1, 2100, 3'b100,  0, 1'b1);
    add(3'b001, 4'h0, 1'b1, 1100, 3'b100,  0, 1'b1);
    add(3'b001, 4'h0, 1'b1,  100, 3'b001,  0, 1'b1);
    add(3'b001, 4'h0, 1'b0,    0, 3'b000,  0, 1'b0);
    add(3'b000, 4'h0, 1'b0,    0, 3'b000,  0, 1'b0);

    reset            = 1'b1;
    i_input_coin     = '0;
    i_output_item    = '0;
    i_trigger_return = 1'b0;
    current_total    = '0;
    #2;
    check_outputs("reset", 3'b000, 32'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      i_input_coin     = vecs[i].coin;
      i_output_item    = vecs[i].item;
      i_trigger_return = vecs[i].trig;
      current_total    = vecs[i].total;
      e.idx    = i;
      e.e_coin = vecs[i].e_coin;
      e.e_wait = vecs[i].e_wait;
      e.e_ret  = vecs[i].e_ret;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_outputs($sformatf("v%0d", e.idx), e.e_coin, e.e_wait, e.e_ret);
    end

    // Reset mid-RETURN while a 100 coin is being shown: clears at once, no more coins.
    @(negedge clk);
    i_input_coin     = '0;
    i_output_item    = '0;
    i_trigger_return = 1'b1;
    current_total    = 31'd300;
    @(posedge clk);
    #1;
    check_outputs("rst_enter", 3'b000, 32'd0, 1'b1);
    @(negedge clk);
    i_trigger_return = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("rst_coin", 3'b001, 32'd0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_outputs("rst_async", 3'b000, 32'd0, 1'b0);
    @(negedge clk);
    reset         = 1'b0;
    current_total = 31'd200;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_outputs($sformatf("post_rst%0d", k), 3'b000, 32'd0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
